// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM responder for instruction fetch and load/store requests
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              failed,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_enable,
  input  logic              ls_request,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [2:0]        ls_size,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_enable,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        len_q, len_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] buf_q, buf_n;
  logic [DATA_W-1:0] if_inst_n, ls_rdata_n;
  logic [ADDR_W-1:0] mem_a_n;
  logic [7:0]        mem_dout_n;
  logic              mem_wr_n, if_en_n, ls_en_n;
  logic [2:0]        cnt_last;
  logic [1:0]        byte_idx;

  function automatic logic [2:0] size_to_len(input logic [2:0] sz);
    case (sz)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      if_inst_o <= '0;
      ls_rdata  <= '0;
      if_enable <= 1'b0;
      ls_enable <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
    end else if (rdy) begin
      state     <= state_n;
      cnt       <= cnt_n;
      len_q     <= len_n;
      wdata_q   <= wdata_n;
      buf_q     <= buf_n;
      if_inst_o <= if_inst_n;
      ls_rdata  <= ls_rdata_n;
      if_enable <= if_en_n;
      ls_enable <= ls_en_n;
      mem_a     <= mem_a_n;
      mem_dout  <= mem_dout_n;
      mem_wr    <= mem_wr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len_q;
    wdata_n    = wdata_q;
    buf_n      = buf_q;
    if_inst_n  = if_inst_o;
    ls_rdata_n = ls_rdata;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    mem_wr_n   = mem_wr;
    if_en_n    = 1'b0;
    ls_en_n    = 1'b0;
    cnt_last   = len_q - 3'd1;
    byte_idx   = cnt[1:0] - 2'd1;

    case (state)
      IDLE: begin
        if (ls_request) begin
          len_n   = size_to_len(ls_size);
          wdata_n = ls_wdata;
          buf_n   = '0;
          mem_a_n = ls_addr;
          cnt_n   = '0;
          if (ls_write) begin
            mem_wr_n   = 1'b1;
            mem_dout_n = ls_wdata[7:0];
            state_n    = LS_WR;
          end else begin
            state_n = LS_RD;
          end
        end else if (if_request && !failed) begin
          len_n   = 3'd4;
          buf_n   = '0;
          mem_a_n = if_addr;
          cnt_n   = '0;
          state_n = IF_RD;
        end
      end

      IF_RD, LS_RD: begin
        if (state == IF_RD && failed) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          // cnt counts cycles since acceptance; byte cnt-1 arrives on mem_din now
          if (cnt != 3'd0)
            buf_n[{byte_idx, 3'b000} +: 8] = mem_din;
          if (cnt < cnt_last)
            mem_a_n = mem_a + ADDR_W'(1);
          if (cnt == len_q) begin
            state_n = IDLE;
            cnt_n   = '0;
            if (state == IF_RD) begin
              if_inst_n = buf_n;
              if_en_n   = 1'b1;
            end else begin
              ls_rdata_n = buf_n;
              ls_en_n    = 1'b1;
            end
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
      end

      LS_WR: begin
        if (cnt < cnt_last) begin
          cnt_n      = cnt + 3'd1;
          mem_a_n    = mem_a + ADDR_W'(1);
          mem_dout_n = wdata_q[{cnt_n[1:0], 3'b000} +: 8];
        end else begin
          mem_wr_n = 1'b0;
          ls_en_n  = 1'b1;
          state_n  = IDLE;
          cnt_n    = '0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_request, failed, if_enable;
  logic [31:0] if_addr, if_inst_o;
  logic        ls_request, ls_write, ls_enable;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [2:0]  ls_size;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ram [0:16383];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_request(if_request), .if_addr(if_addr), .failed(failed),
    .if_inst_o(if_inst_o), .if_enable(if_enable),
    .ls_request(ls_request), .ls_write(ls_write), .ls_addr(ls_addr),
    .ls_size(ls_size), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
    .ls_enable(ls_enable), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM shares the rdy gate with the controller
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[13:0]] <= mem_dout;
      mem_din <= ram[mem_a[13:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
    ram[14'h100] = 8'h13; ram[14'h101] = 8'h05; ram[14'h102] = 8'h00; ram[14'h103] = 8'h00;
    ram[14'h030] = 8'h80; ram[14'h031] = 8'hFF;
    ram[14'h040] = 8'h44; ram[14'h041] = 8'h33; ram[14'h042] = 8'h22; ram[14'h043] = 8'h11;
    ram[14'h200] = 8'h93; ram[14'h201] = 8'h00; ram[14'h202] = 8'h10; ram[14'h203] = 8'h00;
    ram[14'h2002] = 8'h5A;
    mem_din = 8'h00;

    rst = 1'b0; rdy = 1'b1;
    if_request = 1'b0; if_addr = '0; failed = 1'b0;
    ls_request = 1'b0; ls_write = 1'b0; ls_addr = '0; ls_size = 3'd0; ls_wdata = '0;
    tick(); tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
    check("rst_if_en", {31'b0, if_enable}, 32'h0);
    check("rst_ls_en", {31'b0, ls_enable}, 32'h0);
    check("rst_inst", if_inst_o, 32'h0);
    rst = 1'b1;

    // word fetch at 0x100
    if_request = 1'b1; if_addr = 32'h100;
    tick(); check("f_a0", mem_a, 32'h100);
    tick(); check("f_a1", mem_a, 32'h101);
    tick(); check("f_a2", mem_a, 32'h102);
    tick(); check("f_a3", mem_a, 32'h103);
    tick(); check("f_hold", mem_a, 32'h103); check("f_en_early", {31'b0, if_enable}, 32'h0);
    tick(); check("f_en", {31'b0, if_enable}, 32'h1); check("f_inst", if_inst_o, 32'h00000513);
    if_request = 1'b0;
    tick(); check("f_en_drop", {31'b0, if_enable}, 32'h0);

    // store halfword
    ls_request = 1'b1; ls_write = 1'b1; ls_addr = 32'h2000; ls_size = 3'd2; ls_wdata = 32'hAABBCCDD;
    tick(); check("s_wr0", {31'b0, mem_wr}, 32'h1); check("s_a0", mem_a, 32'h2000); check("s_d0", {24'b0, mem_dout}, 32'hDD);
    ls_request = 1'b0;
    tick(); check("s_wr1", {31'b0, mem_wr}, 32'h1); check("s_a1", mem_a, 32'h2001); check("s_d1", {24'b0, mem_dout}, 32'hCC);
    tick(); check("s_wr_off", {31'b0, mem_wr}, 32'h0); check("s_en", {31'b0, ls_enable}, 32'h1);
    tick(); check("s_en_drop", {31'b0, ls_enable}, 32'h0);
    check("s_ram0", {24'b0, ram[14'h2000]}, 32'hDD);
    check("s_ram1", {24'b0, ram[14'h2001]}, 32'hCC);
    check("s_ram2", {24'b0, ram[14'h2002]}, 32'h5A);

    // load byte at 0x30
    ls_request = 1'b1; ls_write = 1'b0; ls_addr = 32'h30; ls_size = 3'd1;
    tick(); check("lb_a", mem_a, 32'h30);
    ls_request = 1'b0;
    tick(); check("lb_en_early", {31'b0, ls_enable}, 32'h0);
    tick(); check("lb_en", {31'b0, ls_enable}, 32'h1); check("lb_data", ls_rdata, 32'h00000080);
    tick(); check("lb_en_drop", {31'b0, ls_enable}, 32'h0);

    // arbitration: word load at 0x40 beats fetch at 0x100
    if_request = 1'b1; if_addr = 32'h100;
    ls_request = 1'b1; ls_write = 1'b0; ls_addr = 32'h40; ls_size = 3'd4;
    tick(); check("arb_ls_first", mem_a, 32'h40);
    ls_request = 1'b0;
    tick(); check("arb_a1", mem_a, 32'h41);
    tick(); check("arb_a2", mem_a, 32'h42);
    tick(); check("arb_a3", mem_a, 32'h43);
    tick(); check("arb_no_if", {31'b0, if_enable}, 32'h0);
    tick(); check("arb_ls_en", {31'b0, ls_enable}, 32'h1); check("arb_ls_data", ls_rdata, 32'h11223344);
    tick(); check("arb_if_start", mem_a, 32'h100); check("arb_ls_drop", {31'b0, ls_enable}, 32'h0);
    tick(); tick(); tick(); tick();
    tick(); check("arb_if_en", {31'b0, if_enable}, 32'h1); check("arb_if_inst", if_inst_o, 32'h00000513);
    if_request = 1'b0;
    tick();

    // flush two cycles into a fetch
    if_request = 1'b1; if_addr = 32'h200;
    tick(); tick();
    failed = 1'b1; if_request = 1'b0;
    tick(); check("fl_a_hold", mem_a, 32'h201);
    failed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fl_no_if_en", {31'b0, if_enable}, 32'h0);
    end
    check("fl_idle_a", mem_a, 32'h201);
    check("fl_inst_keep", if_inst_o, 32'h00000513);
    if_request = 1'b1; if_addr = 32'h200;
    tick(); check("fl2_a0", mem_a, 32'h200);
    tick(); tick(); tick(); tick();
    tick(); check("fl2_en", {31'b0, if_enable}, 32'h1); check("fl2_inst", if_inst_o, 32'h00100093);
    if_request = 1'b0;
    tick();

    // rdy stall mid-fetch
    if_request = 1'b1; if_addr = 32'h100;
    tick(); tick(); tick(); check("rdy_a_pre", mem_a, 32'h102);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy_a_frozen", mem_a, 32'h102);
    end
    rdy = 1'b1;
    tick(); check("rdy_a3", mem_a, 32'h103);
    tick(); check("rdy_en_early", {31'b0, if_enable}, 32'h0);
    tick(); check("rdy_en", {31'b0, if_enable}, 32'h1); check("rdy_inst", if_inst_o, 32'h00000513);
    if_request = 1'b0;
    tick();

    // reset in the middle of a word store
    ls_request = 1'b1; ls_write = 1'b1; ls_addr = 32'h3000; ls_size = 3'd4; ls_wdata = 32'h12345678;
    tick(); check("rs_d0", {24'b0, mem_dout}, 32'h78);
    ls_request = 1'b0;
    tick(); check("rs_a1", mem_a, 32'h3001);
    rst = 1'b0;
    tick();
    check("rs_wr", {31'b0, mem_wr}, 32'h0);
    check("rs_a", mem_a, 32'h0);
    check("rs_dout", {24'b0, mem_dout}, 32'h0);
    check("rs_inst", if_inst_o, 32'h0);
    check("rs_rdata", ls_rdata, 32'h0);
    rst = 1'b1;
    tick(); tick();
    check("rs_wr_stays", {31'b0, mem_wr}, 32'h0);
    check("rs_ls_en", {31'b0, ls_enable}, 32'h0);
    check("rs_ram0", {24'b0, ram[14'h3000]}, 32'h78);
    check("rs_ram2", {24'b0, ram[14'h3002]}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
